// File: rtl/vector_sequencer_pkg.sv
// Shared tester package for the vector sequencer.
// Holds the sequencer state encoding, formatter format codes, the minimum tester-cycle
// period, the load tick, the MEM_DATA field offsets and the period clamp helper.
package vector_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPrime,
      StRun,
      StDrain
   } seq_state_e;

   // Per-channel formatter codes carried in the FF field of each vector word.
   typedef enum logic [1:0] {
      FmtR0    = 2'b00,
      FmtR1    = 2'b01,
      FmtDnrzL = 2'b10,
      FmtDnrzT = 2'b11
   } fmt_code_e;

   // Shortest legal tester cycle: fetch, data return, load and transfer each need a tick.
   localparam logic [7:0] MinPeriod = 8'd4;
   localparam logic [7:0] LoadTick  = 8'd2;

   // MEM_DATA layout: bit 0 is the timing-set select, then 3 bits per channel.
   localparam int unsigned TcBit    = 0;
   localparam int unsigned ChStride = 3;
   localparam int unsigned DOfs     = 1;
   localparam int unsigned FfOfs    = 2;

   function automatic logic [7:0] clamp_period(logic [7:0] len);
      return (len < MinPeriod) ? MinPeriod : len;
   endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Vector memory read port and formatter broadcast bus of the vector sequencer.
//   MEM_RD/MEM_ADDR  : read strobe and address towards the vector memory
//   MEM_DATA         : vector word returned one CLK after MEM_RD
//   LOAD/TRANSFER    : double-buffer strobes broadcast to all channel formatters
//   D/FF             : per-channel drive data and format code, valid while LOAD
//   TEST_CYCLE       : timing-set select of the vector active in the formatters
//   EN_FF_LOGIC      : formatter edge-logic enable
// master: sequencer side; slave: memory/formatter side.
interface vector_sequencer_if #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned ADDR_W = 10
);

   logic                  MEM_RD;
   logic [ADDR_W-1:0]     MEM_ADDR;
   logic [3*NUM_CH:0]     MEM_DATA;
   logic                  LOAD;
   logic                  TRANSFER;
   logic [NUM_CH-1:0]     D;
   logic [2*NUM_CH-1:0]   FF;
   logic                  TEST_CYCLE;
   logic                  EN_FF_LOGIC;

   modport master (
      output MEM_RD,
      output MEM_ADDR,
      input  MEM_DATA,
      output LOAD,
      output TRANSFER,
      output D,
      output FF,
      output TEST_CYCLE,
      output EN_FF_LOGIC
   );

   modport slave (
      input  MEM_RD,
      input  MEM_ADDR,
      output MEM_DATA,
      input  LOAD,
      input  TRANSFER,
      input  D,
      input  FF,
      input  TEST_CYCLE,
      input  EN_FF_LOGIC
   );

endinterface

// File: rtl/cycle_timer.sv
// Tester-cycle tick counter.
//   CLK, RST : clock, synchronous active-high reset
//   en_i     : count while high; held at tick 0 while low
//   len_i    : requested period in CLKs, sampled (and clamped) at tick 0 only
//   tick_o   : current tick within the tester cycle
//   wrap_o   : high on the last tick (period - 1); counter returns to 0 next CLK
module cycle_timer
   import vector_sequencer_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       en_i,
   input  logic [7:0] len_i,
   output logic [7:0] tick_o,
   output logic       wrap_o
);

   logic [7:0] tick_d, tick_q;
   logic [7:0] per_d, per_q;

   always_comb begin
      tick_d = tick_q;
      per_d  = per_q;
      wrap_o = 1'b0;
      if (en_i) begin
         if (tick_q == 8'd0) begin
            // Period is frozen here so mid-cycle length changes wait for the next cycle.
            per_d  = clamp_period(len_i);
            tick_d = 8'd1;
         end else if (tick_q == per_q - 8'd1) begin
            wrap_o = 1'b1;
            tick_d = 8'd0;
         end else begin
            tick_d = tick_q + 8'd1;
         end
      end else begin
         tick_d = 8'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tick_q <= 8'd0;
         per_q  <= MinPeriod;
      end else begin
         tick_q <= tick_d;
         per_q  <= per_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/vector_sequencer.sv
// Vector sequencer: walks vector memory 0..LAST_ADDR, loading each word into the channel
// formatters' double buffers and transferring it on tester-cycle boundaries.
//   CLK, RST                        : clock, synchronous active-high reset
//   START / STOP                    : run start / abort pulses
//   LAST_ADDR                       : final vector address, latched at START
//   CYCLE_LENGTH_1 / CYCLE_LENGTH_2 : tester-cycle period for timing set 1 / 2
//   BUSY / DONE                     : not idle / end-of-run pulse
//   bus                             : memory read port and formatter broadcast bus
module vector_sequencer
   import vector_sequencer_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              STOP,
   input  logic [ADDR_W-1:0] LAST_ADDR,
   input  logic [7:0]        CYCLE_LENGTH_1,
   input  logic [7:0]        CYCLE_LENGTH_2,
   output logic              BUSY,
   output logic              DONE,
   vector_sequencer_if.master bus
);

   localparam int unsigned WordW = 3 * NUM_CH + 1;

   seq_state_e        state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;      // next address to fetch
   logic [ADDR_W-1:0] last_d, last_q;
   logic              more_d, more_q;      // vectors remain to be fetched
   logic              fetched_d, fetched_q;// a vector was fetched this tester cycle
   logic              stop_d, stop_q;
   logic              rd_d, rd_q;          // MEM_DATA valid this CLK
   logic [WordW-1:0]  vec_d, vec_q;
   logic              tc_d, tc_q;
   logic              en_d, en_q;

   logic              timer_en;
   logic [7:0]        timer_len;
   logic [7:0]        tick;
   logic              wrap;

   logic              mem_rd, load, xfer, done;
   logic              stopping;
   logic [NUM_CH-1:0]   d_out;
   logic [2*NUM_CH-1:0] ff_out;

   assign timer_en  = (state_q == StPrime) || (state_q == StRun);
   // PRIME always runs the minimum period; RUN uses the active vector's timing set.
   assign timer_len = (state_q == StPrime) ? MinPeriod :
                      (tc_q ? CYCLE_LENGTH_2 : CYCLE_LENGTH_1);

   cycle_timer u_cycle_timer (
      .CLK    (CLK),
      .RST    (RST),
      .en_i   (timer_en),
      .len_i  (timer_len),
      .tick_o (tick),
      .wrap_o (wrap)
   );

   // A STOP pulse takes effect in the CLK it arrives, not one CLK later.
   assign stopping = stop_q | STOP;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      last_d    = last_q;
      more_d    = more_q;
      fetched_d = fetched_q;
      stop_d    = stop_q;
      tc_d      = tc_q;
      en_d      = en_q;
      mem_rd    = 1'b0;
      load      = 1'b0;
      xfer      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (START) begin
               state_d   = StPrime;
               addr_d    = '0;
               last_d    = LAST_ADDR;
               more_d    = 1'b1;
               fetched_d = 1'b0;
               stop_d    = 1'b0;
            end
         end

         StPrime, StRun: begin
            if (STOP) begin
               stop_d = 1'b1;
            end
            if ((tick == 8'd0) && more_q && !stopping) begin
               mem_rd    = 1'b1;
               fetched_d = 1'b1;
               if (addr_q == last_q) begin
                  more_d = 1'b0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
            if ((tick == LoadTick) && fetched_q && !stopping) begin
               load = 1'b1;
            end
            if (wrap) begin
               fetched_d = 1'b0;
               // An empty tester cycle means the last vector has played out.
               if (stopping || !fetched_q) begin
                  state_d = StDrain;
                  en_d    = 1'b0;
               end else begin
                  xfer    = 1'b1;
                  tc_d    = vec_q[TcBit];
                  en_d    = 1'b1;
                  state_d = StRun;
               end
            end
         end

         StDrain: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign rd_d  = mem_rd;
   assign vec_d = rd_q ? bus.MEM_DATA : vec_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         last_q    <= '0;
         more_q    <= 1'b0;
         fetched_q <= 1'b0;
         stop_q    <= 1'b0;
         rd_q      <= 1'b0;
         vec_q     <= '0;
         tc_q      <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         last_q    <= last_d;
         more_q    <= more_d;
         fetched_q <= fetched_d;
         stop_q    <= stop_d;
         rd_q      <= rd_d;
         vec_q     <= vec_d;
         tc_q      <= tc_d;
         en_q      <= en_d;
      end
   end

   always_comb begin
      d_out  = '0;
      ff_out = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         d_out[n]        = vec_q[DOfs + ChStride * n];
         ff_out[2*n +: 2] = vec_q[FfOfs + ChStride * n +: 2];
      end
   end

   assign bus.MEM_RD      = mem_rd;
   assign bus.MEM_ADDR    = mem_rd ? addr_q : '0;
   assign bus.LOAD        = load;
   assign bus.TRANSFER    = xfer;
   assign bus.D           = d_out;
   assign bus.FF          = ff_out;
   assign bus.TEST_CYCLE  = tc_q;
   assign bus.EN_FF_LOGIC = en_q;
   assign BUSY            = (state_q != StIdle);
   assign DONE            = done;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: a cycle-indexed expectation table is built
// from the run rules (fetch/load/transfer ticks per tester cycle) and compared every CLK.
module tb_vector_sequencer;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WORD_W = 3 * NUM_CH + 1;
   localparam int          MAXT   = 512;

   logic              CLK = 1'b0;
   logic              RST;
   logic              START;
   logic              STOP;
   logic [ADDR_W-1:0] LAST_ADDR;
   logic [7:0]        CL1;
   logic [7:0]        CL2;
   logic              BUSY;
   logic              DONE;

   vector_sequencer_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

   vector_sequencer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .START          (START),
      .STOP           (STOP),
      .LAST_ADDR      (LAST_ADDR),
      .CYCLE_LENGTH_1 (CL1),
      .CYCLE_LENGTH_2 (CL2),
      .BUSY           (BUSY),
      .DONE           (DONE),
      .bus            (bus)
   );

   always #5 CLK = ~CLK;

   logic [WORD_W-1:0] mem [1 << ADDR_W];

   // Memory returns the addressed word one CLK after the strobe, garbage otherwise.
   always @(posedge CLK) begin
      bus.MEM_DATA <= bus.MEM_RD ? mem[bus.MEM_ADDR] : WORD_W'($urandom);
   end

   int checks = 0;
   int errors = 0;

   bit                  e_rd   [MAXT];
   logic [ADDR_W-1:0]   e_addr [MAXT];
   bit                  e_ld   [MAXT];
   logic [3*NUM_CH-1:0] e_fmt  [MAXT];
   bit                  e_xf   [MAXT];
   bit                  e_tc   [MAXT];
   bit                  e_en   [MAXT];
   bit                  e_busy [MAXT];
   bit                  e_done [MAXT];
   int                  cl1_at [MAXT];
   int                  cl2_at [MAXT];
   bit                  last_tc;

   function automatic logic [3*NUM_CH-1:0] fmt_of(logic [WORD_W-1:0] w);
      logic [NUM_CH-1:0]   d;
      logic [2*NUM_CH-1:0] f;
      for (int n = 0; n < NUM_CH; n++) begin
         d[n]        = w[1 + 3*n];
         f[2*n +: 2] = w[2 + 3*n +: 2];
      end
      return {f, d};
   endfunction

   // mode 0: random selects; 1: all select 0; 2: only vector 1 selects timing set 2.
   task automatic fill_mem(input int mode);
      logic [WORD_W-1:0] w;
      for (int a = 0; a < 16; a++) begin
         w = WORD_W'($urandom);
         if (mode == 0) w[0] = 1'($urandom_range(0, 1));
         else           w[0] = (mode == 2) && (a == 1);
         mem[a] = w;
      end
   endtask

   // Cycle 0 carries START; PRIME occupies cycles 1..4; each later tester cycle starts
   // at s, fetches at s, loads at s+2 and transfers at s+L-1.
   task automatic build_model(input int n, input int stop_t, output int done_t);
      int s, len, vec, first_x;
      bit sel;
      for (int t = 0; t < MAXT; t++) begin
         e_rd[t] = 0; e_addr[t] = '0; e_ld[t] = 0; e_fmt[t] = '0; e_xf[t] = 0;
         e_tc[t] = last_tc; e_en[t] = 0; e_busy[t] = 0; e_done[t] = 0;
      end
      s = 1; len = 4; vec = 0; first_x = -1; done_t = -1;
      while (done_t < 0) begin
         if (vec >= 0 && (stop_t < 0 || s < stop_t)) begin
            e_rd[s]   = 1;
            e_addr[s] = ADDR_W'(vec);
         end
         if (vec >= 0 && (stop_t < 0 || s + 2 < stop_t)) begin
            e_ld[s+2]  = 1;
            e_fmt[s+2] = fmt_of(mem[vec]);
         end
         if (vec < 0 || (stop_t >= s && stop_t < s + len)) begin
            done_t = s + len;
         end else begin
            e_xf[s+len-1] = 1;
            if (first_x < 0) first_x = s + len - 1;
            sel = mem[vec][0];
            for (int t = s + len; t < MAXT; t++) e_tc[t] = sel;
            s   = s + len;
            len = sel ? cl2_at[s] : cl1_at[s];
            if (len < 4) len = 4;
            vec = (vec < n) ? vec + 1 : -1;
         end
      end
      if (first_x >= 0) begin
         for (int t = first_x + 1; t < done_t; t++) e_en[t] = 1;
      end
      for (int t = 1; t <= done_t; t++) e_busy[t] = 1;
      e_done[done_t] = 1;
   endtask

   // fc1/fc2 < 0: lengths random and changing mid-run. stop_mode: -1 none, 0 random,
   // >0 STOP at that cycle.
   task automatic run_one(input string name, input int n, input int fc1, input int fc2,
                          input int stop_mode, input bit again, input bit stop_w_start);
      int c1, c2, done_t, stop_t, again_t;
      logic [ADDR_W-1:0]   oaddr;
      logic [3*NUM_CH-1:0] ofmt;
      c1 = (fc1 >= 0) ? fc1 : int'($urandom_range(0, 16));
      c2 = (fc2 >= 0) ? fc2 : int'($urandom_range(0, 16));
      for (int t = 0; t < MAXT; t++) begin
         if (fc1 < 0 && $urandom_range(0, 5) == 0) c1 = int'($urandom_range(0, 16));
         if (fc2 < 0 && $urandom_range(0, 5) == 0) c2 = int'($urandom_range(0, 16));
         cl1_at[t] = c1;
         cl2_at[t] = c2;
      end
      stop_t = (stop_mode > 0) ? stop_mode : -1;
      build_model(n, stop_t, done_t);
      if (stop_mode == 0) begin
         stop_t = int'($urandom_range(1, done_t - 1));
         build_model(n, stop_t, done_t);
      end
      again_t = again ? int'($urandom_range(2, done_t - 1)) : -1;
      for (int t = 0; t <= done_t + 1; t++) begin
         START     = (t == 0) || (t == again_t);
         STOP      = (t == stop_t) || (stop_w_start && t == 0);
         LAST_ADDR = (t == 0) ? ADDR_W'(n) : ADDR_W'($urandom);
         CL1       = 8'(cl1_at[t]);
         CL2       = 8'(cl2_at[t]);
         @(negedge CLK);
         oaddr = bus.MEM_RD ? bus.MEM_ADDR : '0;
         ofmt  = bus.LOAD ? {bus.FF, bus.D} : '0;
         checks++;
         if ({bus.MEM_RD, oaddr, bus.LOAD, ofmt, bus.TRANSFER, bus.TEST_CYCLE,
              bus.EN_FF_LOGIC, BUSY, DONE} !==
             {e_rd[t], e_addr[t], e_ld[t], e_fmt[t], e_xf[t], e_tc[t],
              e_en[t], e_busy[t], e_done[t]}) begin
            errors++;
            $display("FAIL %s t=%0d got rd=%b a=%0d ld=%b fmt=%h xf=%b tc=%b en=%b busy=%b done=%b | want rd=%b a=%0d ld=%b fmt=%h xf=%b tc=%b en=%b busy=%b done=%b",
                     name, t, bus.MEM_RD, oaddr, bus.LOAD, ofmt, bus.TRANSFER,
                     bus.TEST_CYCLE, bus.EN_FF_LOGIC, BUSY, DONE,
                     e_rd[t], e_addr[t], e_ld[t], e_fmt[t], e_xf[t], e_tc[t],
                     e_en[t], e_busy[t], e_done[t]);
         end
         @(posedge CLK);
         #1;
      end
      START   = 1'b0;
      STOP    = 1'b0;
      last_tc = e_tc[done_t];
   endtask

   task automatic test_reset();
      RST = 1'b1; START = 1'b0; STOP = 1'b0; LAST_ADDR = '0; CL1 = 8'd4; CL2 = 8'd4;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({bus.MEM_RD, bus.MEM_ADDR, bus.LOAD, bus.TRANSFER, bus.D, bus.FF, bus.TEST_CYCLE,
           bus.EN_FF_LOGIC, BUSY, DONE} !== '0) begin
         errors++;
         $display("FAIL reset_state got rd=%b a=%0d ld=%b xf=%b d=%h ff=%h tc=%b en=%b busy=%b done=%b want all 0",
                  bus.MEM_RD, bus.MEM_ADDR, bus.LOAD, bus.TRANSFER, bus.D, bus.FF,
                  bus.TEST_CYCLE, bus.EN_FF_LOGIC, BUSY, DONE);
      end
      @(posedge CLK);
      #1;
      RST     = 1'b0;
      last_tc = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      fill_mem(0);
      START = 1'b1; STOP = 1'b0; LAST_ADDR = ADDR_W'(3); CL1 = 8'd10; CL2 = 8'd10;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (6) begin
         @(posedge CLK);
         #1;
      end
      // Cycle 7 is RUN tick 2: the LOAD of vector 1.
      @(negedge CLK);
      checks++;
      if (bus.LOAD !== 1'b1 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre_reset got ld=%b busy=%b want ld=1 busy=1", bus.LOAD, BUSY);
      end
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         checks++;
         if ({bus.MEM_RD, bus.MEM_ADDR, bus.LOAD, bus.TRANSFER, bus.D, bus.FF, bus.TEST_CYCLE,
              bus.EN_FF_LOGIC, BUSY, DONE} !== '0) begin
            errors++;
            $display("FAIL midrun_reset k=%0d got rd=%b ld=%b xf=%b d=%h ff=%h tc=%b en=%b busy=%b done=%b want all 0",
                     k, bus.MEM_RD, bus.LOAD, bus.TRANSFER, bus.D, bus.FF, bus.TEST_CYCLE,
                     bus.EN_FF_LOGIC, BUSY, DONE);
         end
         @(posedge CLK);
         #1;
      end
      last_tc = 1'b0;
      run_one("restart_after_reset", 2, 6, 6, -1, 0, 0);
   endtask

   task automatic test_basic();
      fill_mem(1);
      run_one("basic_l10", 3, 10, 10, -1, 0, 0);
   endtask

   task automatic test_timing_sets();
      fill_mem(2);
      run_one("timing_sets", 3, 8, 12, -1, 0, 0);
   endtask

   task automatic test_clamp();
      fill_mem(1);
      run_one("clamp_l2", 2, 2, 0, -1, 0, 0);
   endtask

   task automatic test_stop();
      fill_mem(1);
      run_one("stop_vec2_tick5", 5, 10, 10, 30, 0, 0);
      fill_mem(0);
      run_one("stop_in_prime", 4, 7, 9, 2, 0, 0);
   endtask

   task automatic test_single();
      fill_mem(0);
      run_one("single_vector", 0, 5, 6, -1, 0, 0);
   endtask

   task automatic test_start_priority();
      fill_mem(0);
      run_one("start_with_stop", 2, 6, 5, -1, 1, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         fill_mem(0);
         run_one("random", int'($urandom_range(0, 7)), -1, -1,
                 ($urandom_range(0, 3) == 0) ? 0 : -1,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timing_sets();
      test_clamp();
      test_stop();
      test_single();
      test_start_priority();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
